// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: wheel direction encoding, quadrature
// decoder states, default counter width and the forward Gray-step helper.
package motor_ctrl_pkg;

  localparam int DEFAULT_CNT_WIDTH = 24;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } dec_state_t;

  // Next {A,B} in the forward cycle 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder_ch.sv
// One quadrature channel: 2-flop synchronizer, optional per-phase stability
// filter (ENC_GLITCH_FILTER_EN), INIT/TRACK x4 decoder, step and error counters.
module quad_decoder_ch
  import motor_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 count_en,
  input  logic                 zero_cnt,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 dir,
  output logic [7:0]           err_cnt
);

  // Elaborates to nothing when the filter length is in range.
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
  end

  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] ab_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {enc_a, enc_b};
      sync2_reg <= sync1_reg;
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  localparam int PIPE_DEPTH = 2 + FILTER_CYCLES;

  logic [1:0] ab_filt;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_filt
    logic       filt_bit_reg;
    logic [3:0] stable_reg;

    // Adopt a new level only after it has been seen FILTER_CYCLES times in a row.
    always_ff @(posedge clk) begin
      if (rst) begin
        filt_bit_reg <= 1'b0;
        stable_reg   <= 4'd0;
      end else if (sync2_reg[gi] == filt_bit_reg) begin
        stable_reg <= 4'd0;
      end else if (stable_reg == 4'(FILTER_CYCLES - 1)) begin
        filt_bit_reg <= sync2_reg[gi];
        stable_reg   <= 4'd0;
      end else begin
        stable_reg <= stable_reg + 4'd1;
      end
    end

    assign ab_filt[gi] = filt_bit_reg;
  end

  assign ab_dec = ab_filt;
`else
  localparam int PIPE_DEPTH = 2;

  assign ab_dec = sync2_reg;
`endif

  // INIT keeps re-capturing prev_ab until the freshly reset input pipeline has
  // refilled, so a level that was present across reset never decodes as a step.
  localparam int INIT_CYCLES = PIPE_DEPTH + 1;

  dec_state_t          state_reg, state_next;
  logic [1:0]          prev_ab_reg, prev_ab_next;
  logic [4:0]          warm_reg, warm_next;
  logic                step, step_rev, illegal;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                dir_reg;
  logic [7:0]          err_reg;

  always_comb begin
    state_next   = state_reg;
    prev_ab_next = prev_ab_reg;
    warm_next    = warm_reg;
    step         = 1'b0;
    step_rev     = 1'b0;
    illegal      = 1'b0;
    case (state_reg)
      INIT: begin
        prev_ab_next = ab_dec;
        if (warm_reg == 5'(INIT_CYCLES - 1)) begin
          state_next = TRACK;
        end else begin
          warm_next = warm_reg + 5'd1;
        end
      end
      TRACK: begin
        prev_ab_next = ab_dec;
        if ((ab_dec ^ prev_ab_reg) == 2'b11) begin
          illegal = 1'b1;
        end else if (ab_dec != prev_ab_reg) begin
          step     = 1'b1;
          step_rev = (ab_dec != gray_fwd_next(prev_ab_reg));
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= INIT;
      prev_ab_reg <= 2'b00;
      warm_reg    <= 5'd0;
      cnt_reg     <= '0;
      dir_reg     <= DIR_FWD;
      err_reg     <= 8'd0;
    end else begin
      state_reg   <= state_next;
      prev_ab_reg <= prev_ab_next;
      warm_reg    <= warm_next;
      if (step) begin
        dir_reg <= step_rev ? DIR_REV : DIR_FWD;
      end
      // Clearing wins over a step decoded on the same edge.
      if (zero_cnt) begin
        cnt_reg <= '0;
        err_reg <= 8'd0;
      end else begin
        if (step && count_en && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (illegal && (err_reg != 8'hFF)) begin
          err_reg <= err_reg + 8'd1;
        end
      end
    end
  end

  assign cnt     = cnt_reg;
  assign dir     = dir_reg;
  assign err_cnt = err_reg;

endmodule

// File: rtl/quad_encoder_counter.sv
// Two-wheel quadrature position counter built from two quad_decoder_ch
// channels; ENC_GLITCH_FILTER_EN enables the per-phase stability filter.
module quad_encoder_counter
  import motor_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc1_a,
  input  logic                 enc1_b,
  input  logic                 enc2_a,
  input  logic                 enc2_b,
  input  logic                 count_en,
  input  logic                 zero_encoders,
  output logic [CNT_WIDTH-1:0] feedback_cnt1,
  output logic [CNT_WIDTH-1:0] feedback_cnt2,
  output logic                 wheel_dir_1,
  output logic                 wheel_dir_2,
  output logic [7:0]           enc_err_cnt1,
  output logic [7:0]           enc_err_cnt2
);

  logic [1:0]           enc_a;
  logic [1:0]           enc_b;
  logic [CNT_WIDTH-1:0] cnt_ch [2];
  logic                 dir_ch [2];
  logic [7:0]           err_ch [2];

  assign enc_a = {enc2_a, enc1_a};
  assign enc_b = {enc2_b, enc1_b};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    quad_decoder_ch #(
      .CNT_WIDTH     (CNT_WIDTH),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enc_a    (enc_a[gi]),
      .enc_b    (enc_b[gi]),
      .count_en (count_en),
      .zero_cnt (zero_encoders),
      .cnt      (cnt_ch[gi]),
      .dir      (dir_ch[gi]),
      .err_cnt  (err_ch[gi])
    );
  end

  assign feedback_cnt1 = cnt_ch[0];
  assign feedback_cnt2 = cnt_ch[1];
  assign wheel_dir_1   = dir_ch[0];
  assign wheel_dir_2   = dir_ch[1];
  assign enc_err_cnt1  = err_ch[0];
  assign enc_err_cnt2  = err_ch[1];

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Scoreboard bench for quad_encoder_counter (4-bit counters so saturation is reachable).
module tb_quad_encoder_counter;

  localparam int CW  = 4;
  localparam int FC  = 4;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT = 3 + FC;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc1_a = 1'b0, enc1_b = 1'b0, enc2_a = 1'b0, enc2_b = 1'b0;
  logic count_en = 1'b1;
  logic zero_encoders = 1'b0;
  logic [CW-1:0] feedback_cnt1, feedback_cnt2;
  logic wheel_dir_1, wheel_dir_2;
  logic [7:0] enc_err_cnt1, enc_err_cnt2;

  quad_encoder_counter #(.CNT_WIDTH(CW), .FILTER_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .enc1_a        (enc1_a),
    .enc1_b        (enc1_b),
    .enc2_a        (enc2_a),
    .enc2_b        (enc2_b),
    .count_en      (count_en),
    .zero_encoders (zero_encoders),
    .feedback_cnt1 (feedback_cnt1),
    .feedback_cnt2 (feedback_cnt2),
    .wheel_dir_1   (wheel_dir_1),
    .wheel_dir_2   (wheel_dir_2),
    .enc_err_cnt1  (enc_err_cnt1),
    .enc_err_cnt2  (enc_err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int    due;
    int    w;
    int    cnt;
    int    dir;
    int    err;
    string tag;
  } sb_t;

  sb_t sb[$];

  // Reference model, wheel index 0 = wheel 1
  int         m_cnt [2] = '{0, 0};
  int         m_dir [2] = '{0, 0};
  int         m_err [2] = '{0, 0};
  logic [1:0] m_ab  [2] = '{2'b00, 2'b00};
  logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_ofs(input int w, input int ofs);
    return gray_seq[(gidx(m_ab[w]) + ofs) % 4];
  endfunction

  function automatic int out_cnt(input int w);
    return (w == 0) ? int'(feedback_cnt1) : int'(feedback_cnt2);
  endfunction
  function automatic int out_dir(input int w);
    return (w == 0) ? int'(wheel_dir_1) : int'(wheel_dir_2);
  endfunction
  function automatic int out_err(input int w);
    return (w == 0) ? int'(enc_err_cnt1) : int'(enc_err_cnt2);
  endfunction

  task automatic set_ab(input int w, input logic [1:0] ab);
    if (w == 0) begin
      enc1_a = ab[1];
      enc1_b = ab[0];
    end else begin
      enc2_a = ab[1];
      enc2_b = ab[0];
    end
  endtask

  task automatic push(input int due, input int w, input string tag);
    sb_t e;
    e.due = due;
    e.w   = w;
    e.cnt = m_cnt[w];
    e.dir = m_dir[w];
    e.err = m_err[w];
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_wheel(input int w, input string tag);
    check_eq({tag, "_cnt"}, out_cnt(w), m_cnt[w]);
    check_eq({tag, "_dir"}, out_dir(w), m_dir[w]);
    check_eq({tag, "_err"}, out_err(w), m_err[w]);
  endtask

  // Drive one raw transition; the old state must still show LAT-1 clocks
  // later and the new state exactly LAT clocks later.
  task automatic drive_step(input int w, input logic [1:0] ab, input bit zero_dec, input string tag);
    int t0;
    int d;
    @(posedge clk);
    #1;
    set_ab(w, ab);
    t0 = cyc;
    push(t0 + LAT - 1, w, {tag, "_pre"});
    d = (gidx(ab) - gidx(m_ab[w])) & 3;
    if (d == 2) begin
      if (m_err[w] < 255) m_err[w]++;
    end else if (d != 0) begin
      m_dir[w] = (d == 3) ? 1 : 0;
      if (count_en && m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
    end
    m_ab[w] = ab;
    if (zero_dec) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_err[k] = 0;
      end
    end
    push(t0 + LAT, w, {tag, "_post"});
    $display("step %s wheel=%0d ab=%b en=%0d zero=%0d exp_cnt=%0d exp_dir=%0d exp_err=%0d",
             tag, w + 1, ab, count_en, zero_dec, m_cnt[w], m_dir[w], m_err[w]);
    if (zero_dec) begin
      repeat (LAT - 1) @(posedge clk);
      #1 zero_encoders = 1'b1;
      @(posedge clk);
      #1 zero_encoders = 1'b0;
    end
    repeat (GAP) @(posedge clk);
  endtask

  // Scoreboard consumer
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          check_eq({e.tag, "_late"}, cyc, e.due);
        end else begin
          check_eq({e.tag, "_cnt"}, out_cnt(e.w), e.cnt);
          check_eq({e.tag, "_dir"}, out_dir(e.w), e.dir);
          check_eq({e.tag, "_err"}, out_err(e.w), e.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ab_tmp;

    // Reset values, checked while reset is held
    repeat (5) @(posedge clk);
    #1;
    check_wheel(0, "rst_w1");
    check_wheel(1, "rst_w2");
    rst = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    check_wheel(0, "idle_w1");
    check_wheel(1, "idle_w2");

    // 8 forward steps on wheel 1
    for (int i = 0; i < 8; i++) drive_step(0, ab_ofs(0, 1), 1'b0, $sformatf("fwd%0d", i));
    check_eq("fwd_cnt1", int'(feedback_cnt1), 8);
    check_eq("fwd_cnt2", int'(feedback_cnt2), 0);
    check_eq("fwd_err1", int'(enc_err_cnt1), 0);

    // 5 reverse steps on wheel 2
    for (int i = 0; i < 5; i++) drive_step(1, ab_ofs(1, 3), 1'b0, $sformatf("rev%0d", i));
    check_eq("rev_cnt2", int'(feedback_cnt2), 5);
    check_eq("rev_dir2", int'(wheel_dir_2), 1);

    // Illegal double-bit change, then a legal step
    drive_step(0, ab_ofs(0, 2), 1'b0, "illegal");
    drive_step(0, ab_ofs(0, 1), 1'b0, "after_ill");

    // Run into saturation at 15 and beyond
    for (int i = 0; i < 9; i++) drive_step(0, ab_ofs(0, 1), 1'b0, $sformatf("sat%0d", i));
    check_eq("sat_cnt1", int'(feedback_cnt1), 15);

    // Clear landing on the same edge as a decoded step
    drive_step(0, ab_ofs(0, 1), 1'b1, "zero_step");
    check_wheel(1, "zero_w2");
    drive_step(0, ab_ofs(0, 1), 1'b0, "post_zero");

    // Counting disabled: direction still tracks
    count_en = 1'b0;
    drive_step(0, ab_ofs(0, 1), 1'b0, "dis0");
    drive_step(0, ab_ofs(0, 1), 1'b0, "dis1");
    drive_step(0, ab_ofs(0, 3), 1'b0, "dis2");
    drive_step(0, ab_ofs(0, 3), 1'b0, "dis3");
    @(posedge clk);
    #1 count_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_wheel(0, "reenable");
    drive_step(0, ab_ofs(0, 1), 1'b0, "en_step");

    // Reset while a step is still in the synchronizer
    @(posedge clk);
    #1;
    ab_tmp = ab_ofs(0, 1);
    set_ab(0, ab_tmp);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ab[0] = ab_tmp;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_dir[k] = 0;
      m_err[k] = 0;
    end
    $display("midreset wheel=1 ab=%b exp_cnt=0", ab_tmp);
    repeat (GAP) @(posedge clk);
    #1;
    check_wheel(0, "midrst_w1");
    check_wheel(1, "midrst_w2");
    drive_step(0, ab_ofs(0, 1), 1'b0, "first_after_rst");

`ifdef ENC_GLITCH_FILTER_EN
    // 3-clock pulse on enc1_a is filtered out
    @(posedge clk);
    #1 enc1_a = ~enc1_a;
    repeat (3) @(posedge clk);
    #1 enc1_a = ~enc1_a;
    $display("glitch wheel=1 len=3 exp_cnt=%0d", m_cnt[0]);
    repeat (GAP) @(posedge clk);
    #1;
    check_wheel(0, "glitch");
    drive_step(0, ab_ofs(0, 1), 1'b0, "filt_step");
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check_eq("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
